// File: rtl/lfsr_period_monitor.sv
// Period checker for an LFSR state stream: locks onto the first sampled state and
// counts valid samples until it recurs, flagging lock-up, tails and maximal length.
module lfsr_period_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             lockup,
  output logic             tail,
  output logic             max_len
);

  // state | meaning
  // IDLE  | waiting for start, samples ignored
  // ARMED | next valid sample becomes the reference state
  // TRACK | counting distinct states until the reference recurs
  // DONE  | result held until start

  localparam int DEPTH = 1 << WIDTH;
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] seen_q, seen_d;
  logic [CNT_W-1:0] period_d;
  logic             lockup_d, tail_d, max_len_d, busy_d, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ref_q   <= '0;
      count_q <= '0;
      seen_q  <= '0;
      period  <= '0;
      lockup  <= 1'b0;
      tail    <= 1'b0;
      max_len <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      seen_q  <= seen_d;
      period  <= period_d;
      lockup  <= lockup_d;
      tail    <= tail_d;
      max_len <= max_len_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    count_d   = count_q;
    seen_d    = seen_q;
    period_d  = period;
    lockup_d  = lockup;
    tail_d    = tail;
    max_len_d = max_len;

    // start overrides everything, including a coincident valid sample
    if (start) begin
      state_d   = ARMED;
      ref_d     = '0;
      count_d   = '0;
      seen_d    = '0;
      period_d  = '0;
      lockup_d  = 1'b0;
      tail_d    = 1'b0;
      max_len_d = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (din_vld) begin
            if (din == '0) begin
              lockup_d = 1'b1;
              period_d = '0;
              state_d  = DONE;
            end else begin
              ref_d       = din;
              seen_d[din] = 1'b1;
              count_d     = CNT_W'(1);
              state_d     = TRACK;
            end
          end
        end
        TRACK: begin
          if (din_vld) begin
            if (din == '0) begin
              lockup_d = 1'b1;
              period_d = '0;
              state_d  = DONE;
            end else if (din == ref_q) begin
              period_d  = count_q;
              max_len_d = (count_q == MAX_P);
              state_d   = DONE;
            end else if (seen_q[din]) begin
              tail_d   = 1'b1;
              period_d = '0;
              state_d  = DONE;
            end else begin
              seen_d[din] = 1'b1;
              count_d     = count_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ARMED) || (state_d == TRACK);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Bench for lfsr_period_monitor: table of sample streams with a result scoreboard,
// plus directed sequences for hold, restart-discard and asynchronous reset.
module tb_lfsr_period_monitor;

  typedef struct packed {
    logic [4:0]  n;
    logic [63:0] s;
    logic [2:0]  gap;
    logic [4:0]  period;
    logic        lockup;
    logic        tail;
    logic        max_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, din_vld;
  logic [3:0] din;
  logic       busy, done, lockup, tail, max_len;
  logic [4:0] period;

  int   ncomp = 0;
  int   nfail = 0;
  vec_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  lfsr_period_monitor #(.WIDTH(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_vld(din_vld),
    .busy(busy), .done(done), .period(period), .lockup(lockup),
    .tail(tail), .max_len(max_len)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    ncomp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_latency"}, lat, 0);
  endtask

  task automatic compare_sb(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_period"}, int'(period), int'(e.period));
      check({tag, "_lockup"}, int'(lockup), int'(e.lockup));
      check({tag, "_tail"}, int'(tail), int'(e.tail));
      check({tag, "_max_len"}, int'(max_len), int'(e.max_len));
      check({tag, "_busy"}, int'(busy), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    pulse_start();
    check({tag, "_armed_busy"}, int'(busy), 1);
    check({tag, "_armed_done"}, int'(done), 0);
    for (int i = 0; i < int'(v.n); i++) begin
      if (i > 0 && v.gap != 0) begin
        din_vld = 1'b0;
        din     = 4'hF;
        repeat (int'(v.gap)) tick();
      end
      din     = v.s[i*4 +: 4];
      din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    sb.push_back(v);
    wait_done(tag);
    compare_sb(tag);
  endtask

  initial begin
    logic [3:0]  st;
    logic [63:0] pk;
    vec_t        e;

    st = 4'hF;
    pk = '0;
    for (int i = 0; i < 16; i++) begin
      pk[i*4 +: 4] = st;
      st = {st[2:0], st[3] ^ st[2]};
    end
    tbl[0] = '{n:5'd16, s:pk,         gap:3'd0, period:5'd15, lockup:1'b0, tail:1'b0, max_len:1'b1};
    tbl[1] = '{n:5'd4,  s:64'h3953,   gap:3'd0, period:5'd3,  lockup:1'b0, tail:1'b0, max_len:1'b0};
    tbl[2] = '{n:5'd4,  s:64'h2421,   gap:3'd0, period:5'd0,  lockup:1'b0, tail:1'b1, max_len:1'b0};
    tbl[3] = '{n:5'd1,  s:64'h0,      gap:3'd0, period:5'd0,  lockup:1'b1, tail:1'b0, max_len:1'b0};
    tbl[4] = '{n:5'd3,  s:64'h0B6,    gap:3'd0, period:5'd0,  lockup:1'b1, tail:1'b0, max_len:1'b0};
    tbl[5] = '{n:5'd4,  s:64'h3953,   gap:3'd5, period:5'd3,  lockup:1'b0, tail:1'b0, max_len:1'b0};
    tbl[6] = '{n:5'd2,  s:64'h77,     gap:3'd0, period:5'd1,  lockup:1'b0, tail:1'b0, max_len:1'b0};

    rst = 1'b0; start = 1'b0; din_vld = 1'b0; din = 4'h0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_period", int'(period), 0);
    check("rst_lockup", int'(lockup), 0);
    check("rst_tail", int'(tail), 0);
    check("rst_max_len", int'(max_len), 0);
    #5 rst = 1'b1;

    din_vld = 1'b1; din = 4'h5;
    repeat (3) tick();
    check("idle_ignore_busy", int'(busy), 0);
    check("idle_ignore_done", int'(done), 0);
    din_vld = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(tbl[k], $sformatf("v%0d", k));

    // DONE holds its result and ignores samples until the next start
    for (int i = 0; i < 5; i++) begin
      din = 4'($urandom_range(15, 0));
      din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    check("hold_done", int'(done), 1);
    check("hold_period", int'(period), 1);
    check("hold_busy", int'(busy), 0);

    // asynchronous reset while in DONE
    #3 rst = 1'b0;
    #1;
    check("rst_done_in_done", int'(done), 0);
    check("rst_period_in_done", int'(period), 0);
    #2 rst = 1'b1;

    // start coincident with a valid sample discards that sample
    pulse_start();
    din = 4'h3; din_vld = 1'b1; tick();
    start = 1'b1; din = 4'h5; tick();
    start = 1'b0;
    check("restart_busy", int'(busy), 1);
    check("restart_done", int'(done), 0);
    din = 4'h5; tick();
    din = 4'h9; tick();
    din = 4'hA; tick();
    din = 4'h5; tick();
    din_vld = 1'b0;
    e = '{n:5'd4, s:64'h5A95, gap:3'd0, period:5'd3, lockup:1'b0, tail:1'b0, max_len:1'b0};
    sb.push_back(e);
    wait_done("restart");
    compare_sb("restart");

    // asynchronous reset mid-TRACK, then samples ignored until start
    pulse_start();
    din = 4'h3; din_vld = 1'b1; tick();
    din = 4'h5; tick();
    din_vld = 1'b0;
    check("track_busy", int'(busy), 1);
    #3 rst = 1'b0;
    #1;
    check("rst_track_busy", int'(busy), 0);
    check("rst_track_done", int'(done), 0);
    check("rst_track_period", int'(period), 0);
    #2 rst = 1'b1;
    din = 4'h3; din_vld = 1'b1;
    repeat (3) tick();
    din_vld = 1'b0;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);

    run_vec(tbl[1], "resume");
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
Downstream checker for the 4-bit LFSR stage. It consumes the LFSR state output each cycle, records the first sampled state, and counts samples until that state recurs. It reports the sequence period and flags three cases: lock-up (all-zeros state), a tail (a non-first state repeating), and a maximal-length sequence. It is used in lab benches and on-board self-check to confirm that the LFSR taps and seed produce the expected 2^WIDTH-1 cycle.

Parameters:
WIDTH, 4, width of the monitored state word (LFSR width)
CNT_W, WIDTH+1, width of the period counter; holds values up to 2^WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  single-cycle pulse; clears all history and arms a new measurement
din  input  WIDTH  LFSR state word (connects to the LFSR output)
din_vld  input  1  din is a new state this cycle (connects to the LFSR shift-enable/sel)
busy  output  1  high in ARMED and TRACK
done  output  1  measurement finished; level held until start or reset
period  output  CNT_W  measured period; 0 when lockup or tail is set
lockup  output  1  an all-zeros state was sampled
tail  output  1  a state other than the reference repeated
max_len  output  1  period == 2^WIDTH-1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, lockup, tail, max_len = 0; period = 0; ref = 0; count = 0; seen bitmap (2^WIDTH bits) = 0. Registers are held while rst=0; operation resumes on the first clk edge after release.
- All outputs are registered. Flags and period update on the same edge that enters DONE. done is visible one clock after the terminating sample is presented.
- States: IDLE, ARMED, TRACK, DONE.
- IDLE and DONE: din_vld is ignored. When start=1, clear the bitmap, count, period and all flags, then go to ARMED. done drops on that edge.
- ARMED, on din_vld=1:
  - din == 0: lockup=1, period=0, go to DONE.
  - Otherwise: ref=din, set seen[din], count=1, go to TRACK.
- TRACK, on din_vld=1, checks applied in this priority order:
  1. din == 0: lockup=1, period=0, go to DONE.
  2. din == ref: period=count, max_len=(count == 2^WIDTH-1), go to DONE.
  3. seen[din] == 1: tail=1, period=0, go to DONE.
  4. Otherwise: set seen[din], count=count+1, stay in TRACK.
- din_vld=0 in ARMED or TRACK: hold all state; gaps in valid samples do not count.
- start=1 in any state (including ARMED or TRACK) restarts: clear history, go to ARMED. start wins over a coincident din_vld, and that sample is discarded.
- Termination is guaranteed within 2^WIDTH valid samples after arming, by pigeonhole on the bitmap. count never exceeds 2^WIDTH, so it cannot overflow CNT_W.
- At most one of lockup, tail, or (period != 0) is set in DONE.
- No combinational path from din or din_vld to any output.

Test Plan:
- LFSR wired in (seed 1111, din_vld = LFSR sel = 1 after load), pulse start -> done after 15 valid samples plus one clock; period=15, max_len=1, lockup=0, tail=0.
- Directed stream 0011, 0101, 1001, 0011 with din_vld=1 -> period=3, max_len=0, done high and held until the next start.
- Directed stream 0001, 0010, 0100, 0010 -> tail=1, period=0, done=1, lockup=0.
- Seed 0000 (LFSR stuck), start then din_vld=1 -> lockup=1, period=0 on the first sample; a mid-track 0000 sample after 0110, 1011 also gives lockup=1.
- Period-3 stream with din_vld dropped for 5 cycles between samples -> period=3 (gaps not counted); start asserted with din_vld on the 2nd sample -> sample discarded, measurement restarts with the next sample as ref.
- rst pulled low mid-TRACK, asynchronously and between clk edges -> all outputs 0 immediately, state IDLE; after release, din_vld is ignored until start.
